spi_peripheral: RTL

//  SPI peripheral (responder) end of the team's SPI link. Receives MSB-first bytes on COPI and

---
 rtl/spi_peripheral.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/spi_peripheral.sv
// SPI responder: oversamples SCLK/COPI/CS_N into i_clk, shifts bytes MSB-first in both
// directions and exchanges them with local logic through a one-deep TX holding register.
module spi_peripheral #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_spi_clk,
  input  logic       i_spi_cs_n,
  input  logic       i_spi_copi,
  output logic       o_spi_cipo,
  output logic       o_spi_cipo_oe,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_dv,
  output logic       o_tx_ready,
  output logic       o_tx_underrun,
  output logic       o_rx_dv,
  output logic [7:0] o_rx_byte
);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_copi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sclk_prev;

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift_tx;
  logic [7:0] r_shift_rx;
  logic [7:0] r_hold;
  logic       r_tx_ready;
  logic       r_cipo;
  logic       r_tx_underrun;
  logic       r_rx_dv;
  logic [7:0] r_rx_byte;

  logic w_sclk;
  logic w_copi;
  logic w_cs_n;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic [7:0] w_rx_next;

  // COPI and SCLK share the same depth so the sampled data bit lines up with its edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sclk_sync <= '0;
      r_copi_sync <= '0;
      r_cs_sync   <= '1;
      r_sclk_prev <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_spi_clk};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], i_spi_copi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_copi      = r_copi_sync[SYNC_STAGES-1];
  assign w_cs_n      = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk & r_sclk_prev;
  assign w_rx_next   = {r_shift_rx[6:0], w_copi};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= 3'd7;
      r_shift_tx    <= '0;
      r_shift_rx    <= '0;
      r_hold        <= '0;
      r_tx_ready    <= 1'b1;
      r_cipo        <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_rx_dv       <= 1'b0;
      r_rx_byte     <= '0;
    end else begin
      r_tx_underrun <= 1'b0;
      r_rx_dv       <= 1'b0;

      // A slot-start consume only happens with r_tx_ready low, so it never collides with a load.
      if (i_tx_dv && r_tx_ready) begin
        r_hold     <= i_tx_byte;
        r_tx_ready <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_bit_cnt <= 3'd7;
          r_cipo    <= 1'b0;
          if (!w_cs_n) r_state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (w_cs_n) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 3'd7;
            r_cipo     <= 1'b0;
            r_shift_rx <= '0;
          end else begin
            if (w_sclk_rise) begin
              if (r_bit_cnt == 3'd7) begin
                if (!r_tx_ready) begin
                  r_shift_tx <= r_hold;
                  r_cipo     <= r_hold[7];
                  r_tx_ready <= 1'b1;
                end else begin
                  r_shift_tx    <= IDLE_BYTE;
                  r_cipo        <= IDLE_BYTE[7];
                  r_tx_underrun <= 1'b1;
                end
              end else begin
                r_cipo <= r_shift_tx[r_bit_cnt];
              end
            end
            if (w_sclk_fall) begin
              r_shift_rx <= w_rx_next;
              r_bit_cnt  <= r_bit_cnt - 3'd1;
              if (r_bit_cnt == 3'd0) begin
                r_rx_byte <= w_rx_next;
                r_rx_dv   <= 1'b1;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_spi_cipo    = r_cipo;
  assign o_spi_cipo_oe = ~w_cs_n;
  assign o_tx_ready    = r_tx_ready;
  assign o_tx_underrun = r_tx_underrun;
  assign o_rx_dv       = r_rx_dv;
  assign o_rx_byte     = r_rx_byte;

endmodule
